id_operand_stage: RTL and testbench

Decode-side operand stage of the 5-stage in-order pipeline.
- Holds the instruction from IF in a valid/allowin stage register and owns the 32×32 register file.
- The register file's write port is driven by the writeback `rf_zip` bus.
- Resolves the two source operands with EX/MEM/WB forwarding and stalls on load-use hazards.
- Delivers `{pc, inst, src1, src2}` to EX.

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/id_operand_stage_if.sv | 27 ++
 rtl/regfile_2r1w.sv | 35 +++
 rtl/id_operand_stage.sv | 110 +++++++++++
 tb/tb_id_operand_stage.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: inter-stage bus widths, forwarding bus layouts
// and the opcode groups whose second source register comes from the rd field.
package pipe_pkg;

  localparam int unsigned FS2DS_W  = 64;
  localparam int unsigned DS2ES_W  = 128;
  localparam int unsigned ES_FWD_W = 40;
  localparam int unsigned MS_FWD_W = 39;
  localparam int unsigned RF_ZIP_W = 38;

  // Branch group, matched on inst[31:26].
  localparam logic [5:0] OpBeq  = 6'h16;
  localparam logic [5:0] OpBne  = 6'h17;
  localparam logic [5:0] OpBlt  = 6'h18;
  localparam logic [5:0] OpBge  = 6'h19;
  localparam logic [5:0] OpBltu = 6'h1A;
  localparam logic [5:0] OpBgeu = 6'h1B;

  // Store group, matched on inst[31:22].
  localparam logic [9:0] OpStB = 10'h0A4;
  localparam logic [9:0] OpStH = 10'h0A5;
  localparam logic [9:0] OpStW = 10'h0A6;

  typedef struct packed {
    logic        valid;
    logic        gr_we;
    logic        res_from_mem;
    logic [4:0]  dest;
    logic [31:0] result;
  } es_fwd_t;

  typedef struct packed {
    logic        valid;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] result;
  } ms_fwd_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_zip_t;

  // Branches and stores read their second operand from rd instead of rk.
  function automatic logic src2_uses_rd(input logic [31:0] inst);
    logic [5:0] op6;
    logic [9:0] op10;
    op6  = inst[31:26];
    op10 = inst[31:22];
    return (op6 inside {OpBeq, OpBne, OpBlt, OpBge, OpBltu, OpBgeu}) ||
           (op10 inside {OpStB, OpStH, OpStW});
  endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Pipeline buses around the decode/operand stage.
//   master: the surrounding pipeline (IF, EX, MEM, WB) driving the stage
//   slave : the decode/operand stage itself
interface id_operand_stage_if;

  logic                          fs2ds_valid;
  logic                          ds_allowin;
  logic [pipe_pkg::FS2DS_W-1:0]  fs2ds_bus;
  logic                          ds2es_valid;
  logic                          es_allowin;
  logic [pipe_pkg::DS2ES_W-1:0]  ds2es_bus;
  logic                          flush;
  logic [pipe_pkg::ES_FWD_W-1:0] es_fwd_zip;
  logic [pipe_pkg::MS_FWD_W-1:0] ms_fwd_zip;
  logic [pipe_pkg::RF_ZIP_W-1:0] rf_zip;

  modport master (
    output fs2ds_valid, fs2ds_bus, es_allowin, flush, es_fwd_zip, ms_fwd_zip, rf_zip,
    input  ds_allowin, ds2es_valid, ds2es_bus
  );

  modport slave (
    input  fs2ds_valid, fs2ds_bus, es_allowin, flush, es_fwd_zip, ms_fwd_zip, rf_zip,
    output ds_allowin, ds2es_valid, ds2es_bus
  );

endinterface

// File: rtl/regfile_2r1w.sv
// 32x32 general register file: two asynchronous read ports, one synchronous
// write port, synchronous active-high clear. r0 reads as zero and is never
// written. No internal write-to-read bypass; the parent handles forwarding.
//   clk, reset         : clock, synchronous active-high reset
//   raddr1_i/rdata1_o  : read port 1
//   raddr2_i/rdata2_o  : read port 2
//   we_i/waddr_i/wdata_i : write port
module regfile_2r1w (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raddr1_i,
  output logic [31:0] rdata1_o,
  input  logic [4:0]  raddr2_i,
  output logic [31:0] rdata2_o,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i
);

  logic [31:0] mem_q [32];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != 5'd0)) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata1_o = (raddr1_i == 5'd0) ? 32'd0 : mem_q[raddr1_i];
  assign rdata2_o = (raddr2_i == 5'd0) ? 32'd0 : mem_q[raddr2_i];

endmodule

// File: rtl/id_operand_stage.sv
// Decode-side operand stage. Holds the instruction from IF in a valid/allowin
// stage register, owns the register file (written from the WB rf_zip bus),
// resolves both source operands with EX/MEM/WB forwarding, stalls on
// load-use hazards and hands {pc, inst, src1, src2} to EX.
//   clk, reset : clock, synchronous active-high reset
//   bus_io     : IF handshake in, EX handshake out, flush, forwarding buses
module id_operand_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  id_operand_stage_if.slave bus_io
);

  logic        ds_valid_q, ds_valid_d;
  logic [31:0] ds_pc_q, ds_pc_d;
  logic [31:0] ds_inst_q, ds_inst_d;

  es_fwd_t es;
  ms_fwd_t ms;
  rf_zip_t wb;
  logic [31:0] fs_pc, fs_inst;

  assign es = bus_io.es_fwd_zip;
  assign ms = bus_io.ms_fwd_zip;
  assign wb = bus_io.rf_zip;
  assign {fs_pc, fs_inst} = bus_io.fs2ds_bus;

  logic [4:0]  src1, src2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [31:0] src1_value, src2_value;
  logic        load_use, ds_ready_go, ds_allowin;

  assign src1 = ds_inst_q[9:5];
  assign src2 = src2_uses_rd(ds_inst_q) ? ds_inst_q[4:0] : ds_inst_q[14:10];

  regfile_2r1w u_regfile (
    .clk      (clk),
    .reset    (reset),
    .raddr1_i (src1),
    .rdata1_o (rf_rdata1),
    .raddr2_i (src2),
    .rdata2_o (rf_rdata2),
    .we_i     (wb.we),
    .waddr_i  (wb.waddr),
    .wdata_i  (wb.wdata)
  );

  // Youngest producer wins. A load in EX has no data yet, so EX is skipped
  // for it and the load-use stall below waits until it reaches MEM.
  function automatic logic [31:0] resolve(input logic [4:0]  src,
                                          input logic [31:0] rf_val,
                                          input es_fwd_t     e,
                                          input ms_fwd_t     m,
                                          input rf_zip_t     w);
    if (src == 5'd0) begin
      return 32'd0;
    end else if (e.valid && e.gr_we && !e.res_from_mem && (e.dest == src)) begin
      return e.result;
    end else if (m.valid && m.gr_we && (m.dest == src)) begin
      return m.result;
    end else if (w.we && (w.waddr == src)) begin
      return w.wdata;
    end else begin
      return rf_val;
    end
  endfunction

  assign src1_value = resolve(src1, rf_rdata1, es, ms, wb);
  assign src2_value = resolve(src2, rf_rdata2, es, ms, wb);

  // Both sources are checked for every instruction (conservative).
  assign load_use = es.valid && es.gr_we && es.res_from_mem && (es.dest != 5'd0) &&
                    ((es.dest == src1) || (es.dest == src2));

  assign ds_ready_go = !load_use;
  assign ds_allowin  = !ds_valid_q || (ds_ready_go && bus_io.es_allowin);

  always_comb begin
    ds_valid_d = ds_valid_q;
    ds_pc_d    = ds_pc_q;
    ds_inst_d  = ds_inst_q;
    if (bus_io.flush) begin
      ds_valid_d = 1'b0;
    end else if (ds_allowin) begin
      ds_valid_d = bus_io.fs2ds_valid;
    end
    if (bus_io.fs2ds_valid && ds_allowin && !bus_io.flush) begin
      ds_pc_d   = fs_pc;
      ds_inst_d = fs_inst;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ds_valid_q <= 1'b0;
      ds_pc_q    <= '0;
      ds_inst_q  <= '0;
    end else begin
      ds_valid_q <= ds_valid_d;
      ds_pc_q    <= ds_pc_d;
      ds_inst_q  <= ds_inst_d;
    end
  end

  assign bus_io.ds_allowin  = ds_allowin;
  assign bus_io.ds2es_valid = ds_valid_q && ds_ready_go && !bus_io.flush;
  assign bus_io.ds2es_bus   = {ds_pc_q, ds_inst_q, src1_value, src2_value};

endmodule

// File: tb/tb_id_operand_stage.sv
module tb_id_operand_stage;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  id_operand_stage_if ifc ();

  id_operand_stage dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (ifc.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        rst;
    logic        fs_valid;
    logic [63:0] fs_bus;
    logic        es_allowin;
    logic        flush;
    logic [39:0] es;
    logic [38:0] ms;
    logic [37:0] rf;
  } in_t;

  typedef struct packed {
    in_t          in;
    logic         ea;
    logic         ev;
    logic [127:0] eb;
  } vec_t;

  // Reference model state: architectural registers and the held instruction.
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [31:0] m_pc, m_inst;

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 1'b0;
    m_pc    = 32'd0;
    m_inst  = 32'd0;
  endtask

  function automatic logic [4:0] m_src2(input logic [31:0] inst);
    int op6, op10;
    op6  = int'(inst >> 26);
    op10 = int'(inst >> 22);
    if ((op6 >= 'h16 && op6 <= 'h1B) || (op10 >= 'h0A4 && op10 <= 'h0A6))
      return inst[4:0];
    return inst[14:10];
  endfunction

  // Newest in-flight value wins; a load still in EX has nothing to give.
  function automatic logic [31:0] m_operand(input in_t v, input logic [4:0] a);
    logic [39:0] e;
    logic [38:0] m;
    logic [37:0] r;
    e = v.es;
    m = v.ms;
    r = v.rf;
    if (a == 0) return 32'd0;
    if (e[39] && e[38] && !e[37] && e[36:32] == a) return e[31:0];
    if (m[38] && m[37] && m[36:32] == a) return m[31:0];
    if (r[37] && r[36:32] == a) return r[31:0];
    return m_regs[a];
  endfunction

  task automatic model_expect(input in_t v, output logic ea, output logic ev,
                              output logic [127:0] eb);
    logic [4:0]  s1, s2;
    logic [39:0] e;
    logic        stall;
    e     = v.es;
    s1    = m_inst[9:5];
    s2    = m_src2(m_inst);
    stall = e[39] && e[38] && e[37] && e[36:32] != 0 && (e[36:32] == s1 || e[36:32] == s2);
    ea    = !m_valid || (!stall && v.es_allowin);
    ev    = m_valid && !stall && !v.flush;
    eb    = {m_pc, m_inst, m_operand(v, s1), m_operand(v, s2)};
  endtask

  task automatic model_commit(input in_t v, input logic ea);
    logic [37:0] r;
    r = v.rf;
    if (v.rst) begin
      model_clear();
    end else begin
      if (r[37] && r[36:32] != 0) m_regs[r[36:32]] = r[31:0];
      if (v.fs_valid && ea && !v.flush) begin
        m_pc   = v.fs_bus[63:32];
        m_inst = v.fs_bus[31:0];
      end
      if (v.flush) m_valid = 1'b0;
      else if (ea) m_valid = v.fs_valid;
    end
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One clock: drive, compare at the falling edge, then advance the model.
  task automatic step(input in_t v, output logic oa, output logic ov, output logic [127:0] ob);
    logic         ea, ev;
    logic [127:0] eb;
    reset            = v.rst;
    ifc.fs2ds_valid  = v.fs_valid;
    ifc.fs2ds_bus    = v.fs_bus;
    ifc.es_allowin   = v.es_allowin;
    ifc.flush        = v.flush;
    ifc.es_fwd_zip   = v.es;
    ifc.ms_fwd_zip   = v.ms;
    ifc.rf_zip       = v.rf;
    @(negedge clk);
    model_expect(v, ea, ev, eb);
    oa = ifc.ds_allowin;
    ov = ifc.ds2es_valid;
    ob = ifc.ds2es_bus;
    check("model ds_allowin", {127'd0, oa}, {127'd0, ea});
    check("model ds2es_valid", {127'd0, ov}, {127'd0, ev});
    check("model ds2es_bus", ob, eb);
    @(posedge clk);
    model_commit(v, ea);
    #1;
  endtask

  function automatic in_t idle();
    in_t v;
    v            = '0;
    v.es_allowin = 1'b1;
    return v;
  endfunction

  function automatic logic [39:0] es_z(input logic vl, input logic we, input logic mem,
                                       input logic [4:0] d, input logic [31:0] res);
    return {vl, we, mem, d, res};
  endfunction

  function automatic logic [38:0] ms_z(input logic vl, input logic we, input logic [4:0] d,
                                       input logic [31:0] res);
    return {vl, we, d, res};
  endfunction

  function automatic logic [37:0] rf_z(input logic we, input logic [4:0] a,
                                       input logic [31:0] d);
    return {we, a, d};
  endfunction

  function automatic vec_t mk(input in_t v, input logic ea, input logic ev,
                              input logic [31:0] pc, input logic [31:0] inst,
                              input logic [31:0] s1, input logic [31:0] s2);
    vec_t r;
    r.in = v;
    r.ea = ea;
    r.ev = ev;
    r.eb = {pc, inst, s1, s2};
    return r;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] base;
    logic [4:0]  rd, rj, rk;
    rd = 5'($urandom_range(0, 7));
    rj = 5'($urandom_range(0, 7));
    rk = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 5))
      0: base = 32'h0010_0000;                                  // add.w
      1: base = 32'($urandom_range('h0A4, 'h0A6)) << 22;        // st.b/h/w
      2: base = 32'($urandom_range('h16, 'h1B)) << 26;          // branches
      3: base = 32'h2880_0000;                                  // ld.w
      4: base = 32'($urandom_range('h1C, 'h3F)) << 26;          // other
      default: return $urandom();
    endcase
    return base | (32'(rk) << 10) | (32'(rj) << 5) | 32'(rd);
  endfunction

  localparam logic [31:0] AddR1R5R6 = 32'h0010_18A1;
  localparam logic [31:0] AddR2R5R0 = 32'h0010_00A2;
  localparam logic [31:0] StwR9R2   = 32'h2980_0049;
  localparam logic [31:0] BeqR1R3   = 32'h5800_0023;
  localparam logic [31:0] AddR1R7R7 = 32'h0010_1CE1;
  localparam logic [31:0] AddR2R4R3 = 32'h0010_0C82;
  localparam logic [31:0] AddR1R0R0 = 32'h0010_0001;

  vec_t         tbl[$];
  in_t          v;
  logic         oa, ov;
  logic [127:0] ob;

  initial begin
    model_clear();
    v = idle();
    reset           = 1'b1;
    ifc.fs2ds_valid = 1'b0;
    ifc.fs2ds_bus   = '0;
    ifc.es_allowin  = 1'b1;
    ifc.flush       = 1'b0;
    ifc.es_fwd_zip  = '0;
    ifc.ms_fwd_zip  = '0;
    ifc.rf_zip      = '0;
    repeat (2) @(posedge clk);
    #1;

    // Directed table: one row per cycle, expectations written out by hand.
    v = idle();
    tbl.push_back(mk(v, 1, 0, 0, 0, 0, 0));                                   // reset state
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h1000, AddR1R5R6};
    tbl.push_back(mk(v, 1, 0, 0, 0, 0, 0));
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h1004, AddR2R5R0};
    v.rf = rf_z(1, 5, 32'h1234_5678);                                         // write-through
    tbl.push_back(mk(v, 1, 1, 32'h1000, AddR1R5R6, 32'h1234_5678, 0));
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h1008, StwR9R2};
    v.rf = rf_z(1, 9, 32'h99);                                                // array read of r5
    tbl.push_back(mk(v, 1, 1, 32'h1004, AddR2R5R0, 32'h1234_5678, 0));
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h100C, BeqR1R3};
    v.rf = rf_z(1, 3, 32'h33);                                                // store src2 = rd
    tbl.push_back(mk(v, 1, 1, 32'h1008, StwR9R2, 0, 32'h99));
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h1010, AddR1R7R7};             // branch src2 = rd
    tbl.push_back(mk(v, 1, 1, 32'h100C, BeqR1R3, 0, 32'h33));
    v = idle(); v.es_allowin = 0;
    v.es = es_z(1, 1, 0, 7, 32'hAAAA_AAAA); v.ms = ms_z(1, 1, 7, 32'hBBBB_BBBB);
    v.rf = rf_z(1, 7, 32'hCCCC_CCCC);                                         // EX wins
    tbl.push_back(mk(v, 0, 1, 32'h1010, AddR1R7R7, 32'hAAAA_AAAA, 32'hAAAA_AAAA));
    v.es = '0;                                                                // MEM wins
    tbl.push_back(mk(v, 0, 1, 32'h1010, AddR1R7R7, 32'hBBBB_BBBB, 32'hBBBB_BBBB));
    v.ms = '0;                                                                // WB wins
    tbl.push_back(mk(v, 0, 1, 32'h1010, AddR1R7R7, 32'hCCCC_CCCC, 32'hCCCC_CCCC));
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h1014, AddR2R4R3};             // array
    tbl.push_back(mk(v, 1, 1, 32'h1010, AddR1R7R7, 32'hCCCC_CCCC, 32'hCCCC_CCCC));
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h1018, AddR1R0R0};
    v.es = es_z(1, 1, 1, 4, 32'hDEAD_BEEF);                                   // load-use bubble
    tbl.push_back(mk(v, 0, 0, 32'h1014, AddR2R4R3, 0, 32'h33));
    v.es = '0; v.ms = ms_z(1, 1, 4, 32'h55);                                  // load from MEM
    tbl.push_back(mk(v, 1, 1, 32'h1014, AddR2R4R3, 32'h55, 32'h33));
    v = idle(); v.es_allowin = 0; v.es = es_z(1, 1, 0, 0, 32'hFFFF_FFFF);     // r0 vs EX
    tbl.push_back(mk(v, 0, 1, 32'h1018, AddR1R0R0, 0, 0));
    v = idle(); v.es = es_z(1, 1, 1, 0, 32'hFFFF_FFFF);                       // r0 load: no stall
    tbl.push_back(mk(v, 1, 1, 32'h1018, AddR1R0R0, 0, 0));
    v = idle();
    tbl.push_back(mk(v, 1, 0, 32'h1018, AddR1R0R0, 0, 0));
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h2000, AddR2R4R3};
    tbl.push_back(mk(v, 1, 0, 32'h1018, AddR1R0R0, 0, 0));
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h2004, AddR1R0R0};
    v.es = es_z(1, 1, 1, 4, 32'h1); v.flush = 1;                              // flush in stall
    tbl.push_back(mk(v, 0, 0, 32'h2000, AddR2R4R3, 0, 32'h33));
    v = idle();
    tbl.push_back(mk(v, 1, 0, 32'h2000, AddR2R4R3, 0, 32'h33));
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h3000, AddR1R5R6}; v.flush = 1; // flush blocks capture
    tbl.push_back(mk(v, 1, 0, 32'h2000, AddR2R4R3, 0, 32'h33));
    v = idle();
    tbl.push_back(mk(v, 1, 0, 32'h2000, AddR2R4R3, 0, 32'h33));

    foreach (tbl[i]) begin
      step(tbl[i].in, oa, ov, ob);
      check($sformatf("row%0d ds_allowin", i), {127'd0, oa}, {127'd0, tbl[i].ea});
      check($sformatf("row%0d ds2es_valid", i), {127'd0, ov}, {127'd0, tbl[i].ev});
      check($sformatf("row%0d ds2es_bus", i), ob, tbl[i].eb);
    end

    // Backpressure: the held instruction stays put while EX refuses it.
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h4000, AddR1R5R6};
    step(v, oa, ov, ob);
    v.fs_bus = {32'h4004, AddR2R4R3}; v.es_allowin = 0;
    for (int c = 0; c < 3; c++) begin
      step(v, oa, ov, ob);
      check($sformatf("bp%0d ds_allowin", c), {127'd0, oa}, 128'd0);
      check($sformatf("bp%0d pc/inst", c), {64'd0, ob[127:64]}, {64'd0, 32'h4000, AddR1R5R6});
    end
    // Stall on r5 load, then flush: stage drops the instruction.
    v.es = es_z(1, 1, 1, 5, 32'h7);
    step(v, oa, ov, ob);
    check("stall ds2es_valid", {127'd0, ov}, 128'd0);
    v.flush = 1;
    step(v, oa, ov, ob);
    v = idle();
    step(v, oa, ov, ob);
    check("post-flush ds2es_valid", {127'd0, ov}, 128'd0);
    check("post-flush ds_allowin", {127'd0, oa}, 128'd1);

    // Reset in the middle of a load-use stall.
    v = idle(); v.fs_valid = 1; v.fs_bus = {32'h5000, AddR1R5R6};
    step(v, oa, ov, ob);
    v = idle(); v.es = es_z(1, 1, 1, 6, 32'h9);
    step(v, oa, ov, ob);
    check("pre-reset stall ds_allowin", {127'd0, oa}, 128'd0);
    v.rst = 1;
    step(v, oa, ov, ob);
    v = idle();
    step(v, oa, ov, ob);
    check("post-reset ds_allowin", {127'd0, oa}, 128'd1);
    check("post-reset ds2es_valid", {127'd0, ov}, 128'd0);
    check("post-reset ds2es_bus", ob, 128'd0);

    // Randomized traffic against the model, small register indices for hits.
    for (int n = 0; n < 3000; n++) begin
      v            = '0;
      v.rst        = ($urandom_range(0, 199) == 0);
      v.fs_valid   = ($urandom_range(0, 3) != 0);
      v.fs_bus     = {$urandom(), rand_inst()};
      v.es_allowin = ($urandom_range(0, 3) != 0);
      v.flush      = ($urandom_range(0, 9) == 0);
      v.es = es_z(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)),
                  $urandom());
      v.ms = ms_z(1'($urandom), 1'($urandom), 5'($urandom_range(0, 7)), $urandom());
      v.rf = rf_z(1'($urandom), 5'($urandom_range(0, 7)), $urandom());
      step(v, oa, ov, ob);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
